// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_W    = 32;
    localparam int MDU_ITER = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    function automatic logic [MDU_W-1:0] neg_if(input logic [MDU_W-1:0] v, input logic n);
        if (n) begin
            return {MDU_W{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [MDU_W-1:0] abs_val(input logic [MDU_W-1:0] v);
        return neg_if(v, v[MDU_W-1]);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the main control unit and the multiply/divide unit.
interface mult_div_unit_if;
    import mdu_pkg::*;

    logic             start;
    logic             op;
    logic [MDU_W-1:0] a;
    logic [MDU_W-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [MDU_W-1:0] hi;
    logic [MDU_W-1:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: a radix-2 Booth step or a restoring-division step.
module mdu_step
    import mdu_pkg::*;
(
    input  mdu_state_t       state_i,
    input  logic [64:0]      acc_i,
    input  logic [MDU_W-1:0] mcand_i,
    input  logic [MDU_W:0]   rem_i,
    input  logic [MDU_W-1:0] quo_i,
    input  logic [MDU_W-1:0] dvsr_i,
    output logic [64:0]      acc_o,
    output logic [MDU_W:0]   rem_o,
    output logic [MDU_W-1:0] quo_o
);

    logic [MDU_W:0] upper_s;
    logic [MDU_W:0] mcand_x_s;
    logic [MDU_W:0] sum_s;
    logic [MDU_W:0] trial_s;
    logic [MDU_W:0] diff_s;

    // Booth add/sub on a 33-bit upper half so the shift keeps the true sign; restoring compare/subtract
    always_comb begin
        acc_o     = acc_i;
        rem_o     = rem_i;
        quo_o     = quo_i;
        upper_s   = {acc_i[64], acc_i[64:33]};
        mcand_x_s = {mcand_i[MDU_W-1], mcand_i};
        sum_s     = upper_s;
        trial_s   = {rem_i[MDU_W-1:0], quo_i[MDU_W-1]};
        diff_s    = trial_s - {1'b0, dvsr_i};
        case (state_i)
            ST_MULT: begin
                case (acc_i[1:0])
                    2'b01:   sum_s = upper_s + mcand_x_s;
                    2'b10:   sum_s = upper_s - mcand_x_s;
                    default: sum_s = upper_s;
                endcase
                acc_o = {sum_s, acc_i[32:1]};
            end
            ST_DIV: begin
                if (trial_s >= {1'b0, dvsr_i}) begin
                    rem_o = diff_s;
                    quo_o = {quo_i[MDU_W-2:0], 1'b1};
                end else begin
                    rem_o = trial_s;
                    quo_o = {quo_i[MDU_W-2:0], 1'b0};
                end
            end
            default: begin
                acc_o = acc_i;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV sequencer with HI/LO result registers.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    mdu_state_t       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [64:0]      acc_q, acc_d;
    logic [MDU_W-1:0] mcand_q, mcand_d;
    logic [MDU_W:0]   rem_q, rem_d;
    logic [MDU_W-1:0] quo_q, quo_d;
    logic [MDU_W-1:0] dvsr_q, dvsr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_pend_q, dz_pend_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [MDU_W-1:0] hi_q, hi_d;
    logic [MDU_W-1:0] lo_q, lo_d;

    logic [64:0]      step_acc_s;
    logic [MDU_W:0]   step_rem_s;
    logic [MDU_W-1:0] step_quo_s;
    logic             last_s;

    mdu_step u_step (
        .state_i (state_q),
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .rem_i   (rem_q),
        .quo_i   (quo_q),
        .dvsr_i  (dvsr_q),
        .acc_o   (step_acc_s),
        .rem_o   (step_rem_s),
        .quo_o   (step_quo_s)
    );

    assign last_s = (cnt_q == 5'(MDU_ITER - 1));

    // Next-state, datapath latching and result write-back
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dz_pend_d = 1'b0;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 5'd0;
                if (dz_pend_q) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
                if (bus.start && (bus.op == OP_MULT)) begin
                    state_d = ST_MULT;
                    acc_d   = {32'd0, bus.b, 1'b0};
                    mcand_d = bus.a;
                end else if (bus.start && (bus.b != 32'd0)) begin
                    state_d = ST_DIV;
                    rem_d   = 33'd0;
                    quo_d   = abs_val(bus.a);
                    dvsr_d  = abs_val(bus.b);
                    negq_d  = bus.a[MDU_W-1] ^ bus.b[MDU_W-1];
                    negr_d  = bus.a[MDU_W-1];
                end else if (bus.start) begin
                    dz_pend_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT: begin
                acc_d = step_acc_s;
                cnt_d = cnt_q + 5'd1;
                if (last_s) begin
                    hi_d    = step_acc_s[64:33];
                    lo_d    = step_acc_s[32:1];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MULT;
                end
            end
            ST_DIV: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q + 5'd1;
                if (last_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                // Truncating division: quotient sign from operand XOR, remainder follows dividend
                lo_d    = neg_if(quo_q, negq_q);
                hi_d    = neg_if(rem_q[MDU_W-1:0], negr_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 65'd0;
            mcand_q   <= 32'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            dz_pend_q <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            dz_pend_q <= dz_pend_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench: issued ops push expected HI/LO/flag/arrival cycle; a monitor checks on done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clock = 1'b0;
    logic reset;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && bus.div_zero === 1'b1) check("div_zero_without_done", 64'(bus.done), 64'd1);
        if (!reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                check("latency", 64'(cyc), 64'(e.due));
                check("busy_in_done_cycle", 64'(bus.busy), 64'd0);
            end
        end
    end

    // Issue one op at the current negedge; the model computes results with wide signed arithmetic
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        logic [63:0] pv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0;
        if (op == OP_MULT) begin
            p  = sa * sbv;
            pv = p;
            e.hi = pv[63:32];
            e.lo = pv[31:0];
            e.due = cyc + 1 + 32;
        end else if (b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
            e.due = cyc + 1 + 1;
        end else begin
            pv = sa / sbv;
            e.lo = pv[31:0];
            pv = sa % sbv;
            e.hi = pv[31:0];
            e.due = cyc + 1 + 33;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (sb_q.size() != 0) begin
            check("timeout_waiting_done", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        reset     = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_empty();
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_empty();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_empty();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_empty();

        // Divide by zero keeps the previous HI/LO and never raises busy
        issue(OP_DIV, 32'd5, 32'd0);
        check("dz_busy_low", 64'(bus.busy), 64'd0);
        wait_empty();
        check("dz_busy_after", 64'(bus.busy), 64'd0);

        // A start during busy is ignored; a start in the done cycle is taken
        issue(OP_MULT, 32'd1234, 32'hFFFF_FFFB);
        repeat (9) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (bus.done === 1'b1) break;
        end
        check("done_seen_for_b2b", 64'(bus.done), 64'd1);
        issue(OP_MULT, 32'd3, 32'd5);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_empty();

        // Reset in the middle of a divide discards it
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        issue(OP_MULT, 32'd3, 32'd4);
        wait_empty();

        for (int n = 0; n < 40; n++) begin
            logic        op;
            logic [31:0] a;
            logic [31:0] b;
            op = 1'($urandom_range(0, 1));
            a  = rand_val();
            b  = rand_val();
            issue(op, a, b);
            wait_empty();
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
